// File: rtl/sum_burst_tx_pkg.sv
// Shared types and constants for the burst transmitter.
package sum_burst_tx_pkg;

  localparam int BURST_LEN = 128;
  localparam int ADDR_W    = $clog2(BURST_LEN);
  localparam int SUM_W     = 17;
  localparam int DATA_W    = 8;

  typedef enum logic [1:0] {
    FILL     = 2'd0,
    START    = 2'd1,
    SEND     = 2'd2,
    WAIT_SUM = 2'd3
  } state_t;

endpackage

// File: rtl/sum_burst_tx_buffer.sv
// Burst byte buffer: one write port, one read port, registered read (1-cycle latency).
module burst_buffer
  import sum_burst_tx_pkg::*;
#(
  parameter int DEPTH = BURST_LEN,
  parameter int AW    = ADDR_W
) (
  input  logic              CLK,
  input  logic              i_wr_en,
  input  logic [AW-1:0]     i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [AW-1:0]     i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Plain RAM without reset so it maps onto block RAM; read data registered.
  always_ff @(posedge CLK) begin
    if (i_wr_en)
      r_mem[i_wr_addr] <= i_wr_data;
    o_rd_data <= r_mem[i_rd_addr];
  end

endmodule

// File: rtl/sum_burst_tx.sv
// Burst transmitter: buffers a host burst, frames it out to the accumulator,
// sums it locally and checks the accumulator's returned sum (or times out).
module sum_burst_tx #(
  parameter int BURST_LEN = sum_burst_tx_pkg::BURST_LEN,
  parameter int TIMEOUT   = 255
) (
  input  logic                              CLK,
  input  logic                              RST_n,
  input  logic                              wr_en,
  input  logic [sum_burst_tx_pkg::DATA_W-1:0] wr_data,
  output logic                              wr_ready,
  output logic                              tx_start,
  output logic [sum_burst_tx_pkg::DATA_W-1:0] tx_data,
  input  logic [sum_burst_tx_pkg::SUM_W-1:0]  sum_in,
  input  logic                              sum_enable,
  output logic [sum_burst_tx_pkg::SUM_W-1:0]  expected_sum,
  output logic                              done,
  output logic                              match,
  output logic                              timeout,
  output logic                              busy
);
  import sum_burst_tx_pkg::*;

  localparam int AW = $clog2(BURST_LEN);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(BURST_LEN - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW-1:0]     r_cnt;
  logic [TW-1:0]     r_tmo_cnt;
  logic [SUM_W-1:0]  r_exp_sum;
  logic              r_done;
  logic              r_match;
  logic              r_timeout;
  logic              w_wr_accept;
  logic [DATA_W-1:0] w_rd_data;

  assign w_wr_accept  = wr_en && (r_state == FILL);
  assign tx_data      = (r_state == SEND) ? w_rd_data : '0;
  assign expected_sum = r_exp_sum;
  assign done         = r_done;
  assign match        = r_match;
  assign timeout      = r_timeout;

  burst_buffer #(
    .DEPTH (BURST_LEN),
    .AW    (AW)
  ) u_buffer (
    .CLK       (CLK),
    .i_wr_en   (w_wr_accept),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (wr_data),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  // Next-state and state-decoded strobes.
  always_comb begin
    w_state_next = r_state;
    wr_ready     = 1'b0;
    tx_start     = 1'b0;
    busy         = 1'b1;
    case (r_state)
      FILL: begin
        wr_ready = 1'b1;
        busy     = 1'b0;
        if (w_wr_accept && (r_wr_ptr == LAST_IDX))
          w_state_next = START;
      end
      START: begin
        tx_start     = 1'b1;
        w_state_next = SEND;
      end
      SEND: begin
        if (r_cnt == LAST_IDX)
          w_state_next = WAIT_SUM;
      end
      WAIT_SUM: begin
        if (sum_enable || (r_tmo_cnt == '0))
          w_state_next = FILL;
      end
      default: w_state_next = FILL;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n)
      r_state <= FILL;
    else
      r_state <= w_state_next;
  end

  // Write/read pointers and byte counter; the START read of address 0 lines byte 0 up with the first SEND cycle.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        FILL: begin
          if (w_wr_accept)
            r_wr_ptr <= r_wr_ptr + 1'b1;
          r_rd_ptr <= '0;
          r_cnt    <= '0;
        end
        START: r_rd_ptr <= r_rd_ptr + 1'b1;
        SEND: begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
          r_cnt    <= r_cnt + 1'b1;
        end
        WAIT_SUM: begin
          if (w_state_next == FILL) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Running sum, timeout countdown and registered result flags; sum_enable beats expiry.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_exp_sum <= '0;
      r_tmo_cnt <= '0;
      r_done    <= 1'b0;
      r_match   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        START: begin
          r_exp_sum <= '0;
          r_match   <= 1'b0;
          r_timeout <= 1'b0;
        end
        SEND: begin
          r_exp_sum <= r_exp_sum + SUM_W'(w_rd_data);
          r_tmo_cnt <= TW'(TIMEOUT);
        end
        WAIT_SUM: begin
          if (sum_enable) begin
            r_match <= (sum_in == r_exp_sum);
            r_done  <= 1'b1;
          end else if (r_tmo_cnt == '0) begin
            r_timeout <= 1'b1;
            r_match   <= 1'b0;
            r_done    <= 1'b1;
          end else begin
            r_tmo_cnt <= r_tmo_cnt - TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sum_burst_tx.sv
// Randomized self-checking bench for sum_burst_tx against a burst-level reference model.
module tb_sum_burst_tx;

  localparam int BL  = 128;
  localparam int TMO = 255;

  logic        CLK = 1'b0;
  logic        RST_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = '0;
  logic        wr_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [16:0] sum_in = '0;
  logic        sum_enable = 1'b0;
  logic [16:0] expected_sum;
  logic        done;
  logic        match;
  logic        timeout;
  logic        busy;

  always #5 CLK = ~CLK;

  sum_burst_tx #(
    .BURST_LEN (BL),
    .TIMEOUT   (TMO)
  ) dut (
    .CLK          (CLK),
    .RST_n        (RST_n),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .sum_in       (sum_in),
    .sum_enable   (sum_enable),
    .expected_sum (expected_sum),
    .done         (done),
    .match        (match),
    .timeout      (timeout),
    .busy         (busy)
  );

  int         err_cnt = 0;
  int         chk_cnt = 0;
  int         burst_no = 0;
  logic [7:0] bytes_q [BL];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    chk_cnt++;
    if (got !== want) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reset-value vector: {tx_data, expected_sum, wr_ready, busy, tx_start, done, match, timeout}.
  task automatic chk_reset_outs(input string tag);
    chk(tag, {tx_data, expected_sum, wr_ready, busy, tx_start, done, match, timeout},
        {8'h00, 17'h0, 6'b100000});
  endtask

  // One burst: fill, observe framing, answer with ret d cycles after WAIT_SUM entry
  // (d > TMO means never). rst_at >= 0 pulses reset while that byte is on tx_data.
  task automatic run_burst(input int d, input logic [16:0] ret, input bit hammer, input int rst_at);
    int         model_sum;
    int         i;
    int         n;
    int         want_n;
    int         starts;
    bit         want_to;
    bit         want_match;
    bit         en;

    model_sum = 0;
    foreach (bytes_q[k]) model_sum += int'(bytes_q[k]);

    // Fill phase: host gaps and stray sum_enable pulses when hammering.
    i = 0;
    while (i < BL) begin
      en      = hammer ? ($urandom_range(0, 3) != 0) : 1'b1;
      wr_en   = en;
      wr_data = en ? bytes_q[i] : 8'($urandom);
      sum_enable = hammer ? 1'($urandom) : 1'b0;
      sum_in  = 17'($urandom);
      chk("fill_idle", {wr_ready, busy, done, tx_start}, 4'b1000);
      tick();
      if (en) i++;
    end
    sum_enable = 1'b0;

    // START cycle.
    chk("start", {tx_start, wr_ready, busy}, 3'b101);
    wr_en   = hammer ? 1'($urandom) : 1'b0;
    wr_data = 8'($urandom);
    tick();

    // SEND cycles.
    starts = 0;
    for (int k = 0; k < BL; k++) begin
      if (k == rst_at) begin
        RST_n = 1'b0;
        wr_en = 1'b0;
        #1;
        chk_reset_outs("mid_reset");
        #1;
        RST_n = 1'b1;
        $display("burst %0d: reset at byte %0d", burst_no, k);
        burst_no++;
        return;
      end
      chk("tx_byte", {tx_data, wr_ready}, {bytes_q[k], 1'b0});
      if (tx_start) starts++;
      wr_en   = hammer ? 1'($urandom) : 1'b0;
      wr_data = 8'($urandom);
      tick();
    end
    chk("single_start", starts, 0);

    // First WAIT_SUM cycle.
    chk("wait_entry", {tx_data, tx_start, done, busy, wr_ready}, {8'h00, 4'b0010});
    chk("exp_sum", expected_sum, 32'(model_sum));

    // Response phase, bounded.
    n = 0;
    while (1) begin
      sum_enable = (n == d);
      sum_in     = (n == d) ? ret : 17'($urandom);
      wr_en      = hammer ? 1'($urandom) : 1'b0;
      wr_data    = 8'($urandom);
      tick();
      n++;
      if (done || n > TMO + 4) break;
    end
    sum_enable = 1'b0;
    wr_en      = 1'b0;

    want_to    = (d > TMO);
    want_n     = want_to ? TMO + 1 : d + 1;
    want_match = !want_to && (ret == 17'(model_sum));
    chk("done_cycle", n, want_n);
    chk("result", {done, match, timeout, wr_ready, busy}, {1'b1, want_match, want_to, 2'b10});
    chk("exp_hold", expected_sum, 32'(model_sum));
    $display("burst %0d: exp_sum=%05h ret=%05h d=%0d -> done@%0d match=%0d timeout=%0d",
             burst_no, expected_sum, ret, d, n, match, timeout);
    burst_no++;

    tick();
    chk("done_pulse", {done, match, timeout}, {1'b0, want_match, want_to});
  endtask

  function automatic logic [16:0] sum_of_bytes();
    int s = 0;
    foreach (bytes_q[k]) s += int'(bytes_q[k]);
    return 17'(s);
  endfunction

  task automatic fill_random();
    foreach (bytes_q[k]) bytes_q[k] = 8'($urandom);
  endtask

  initial begin
    // Reset state.
    #1;
    chk_reset_outs("reset_state");
    tick();
    chk_reset_outs("reset_held");
    #2;
    RST_n = 1'b1;
    tick();

    // Ascending bytes, immediate correct answer.
    foreach (bytes_q[k]) bytes_q[k] = 8'(k);
    run_burst(0, 17'h01FC0, 1'b0, -1);

    // All 0xFF: correct, then wrong answer.
    foreach (bytes_q[k]) bytes_q[k] = 8'hFF;
    run_burst($urandom_range(0, 20), 17'h07F80, 1'b0, -1);
    run_burst($urandom_range(0, 20), 17'h07F7F, 1'b0, -1);

    // No answer: timeout.
    fill_random();
    run_burst(TMO + 1000, 17'h0, 1'b0, -1);

    // Answer in the very cycle the countdown reaches zero.
    fill_random();
    run_burst(TMO, sum_of_bytes(), 1'b0, -1);

    // Host and accumulator noise outside their windows.
    fill_random();
    run_burst($urandom_range(0, 40), sum_of_bytes(), 1'b1, -1);
    fill_random();
    run_burst($urandom_range(0, 40), sum_of_bytes(), 1'b1, -1);

    // Reset during byte 60, then a clean burst.
    fill_random();
    run_burst(0, 17'h0, 1'b0, 60);
    fill_random();
    run_burst($urandom_range(0, 10), sum_of_bytes(), 1'b0, -1);

    // Random mix.
    for (int r = 0; r < 6; r++) begin
      fill_random();
      run_burst($urandom_range(0, TMO + 20),
                ($urandom_range(0, 1) != 0) ? sum_of_bytes() : 17'($urandom),
                1'($urandom), -1);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
